// File: rtl/tt_um_hoene_protocol_sequencer_pkg.sv
// Shared types and constants for the smart-LED frame sequencer.
// State encoding, word width and default test pattern.
package tt_um_hoene_protocol_sequencer_pkg;

    localparam int WORD_BITS = 32;
    localparam logic [WORD_BITS-1:0] DEFAULT_TEST_PATTERN = 32'hFF00_FF00;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FORWARD = 3'd3,
        ST_TEST    = 3'd4
    } state_t;

endpackage

// File: rtl/tt_um_hoene_protocol_sequencer_word_shifter.sv
// MSB-first serial-in/parallel-out word register with synchronous clear.
// Used to collect this LED's own data word.
module tt_um_hoene_word_shifter
    import tt_um_hoene_protocol_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic [WORD_BITS-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WORD_BITS-2:0], din};
        end
    end

endmodule

// File: rtl/tt_um_hoene_protocol_sequencer.sv
// Frame sequencer: strips the first word of each frame for this LED,
// forwards the rest, and publishes the word (or a test pattern) at frame end.
//
// state   | meaning
// SYNC    | after reset, waiting for an inter-frame gap
// IDLE    | gap, waiting for the next frame
// CAPTURE | shifting in this LED's own word
// FORWARD | passing remaining bits downstream
// TEST    | counters flagged test mode, output suppressed
module tt_um_hoene_protocol_sequencer
    import tt_um_hoene_protocol_sequencer_pkg::*;
#(
    parameter logic [31:0] TEST_PATTERN = DEFAULT_TEST_PATTERN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_clk,
    input  logic        s_data,
    input  logic        s_frame,
    input  logic [4:0]  bit_counter,
    input  logic        test_mode,
    output logic [31:0] led_word,
    output logic        led_valid,
    output logic        fwd_clk,
    output logic        fwd_data,
    output logic        fwd_frame
);

    state_t state, state_nxt;

    logic                 shift_clr;
    logic                 shift_en;
    logic [WORD_BITS-1:0] shift_q;
    logic                 fwd_clk_nxt;
    logic                 fwd_data_nxt;
    logic                 pub_word;
    logic                 pub_test;

    tt_um_hoene_word_shifter u_shifter (
        .clk (clk),
        .rst (rst),
        .clr (shift_clr),
        .en  (shift_en),
        .din (s_data),
        .q   (shift_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame end has priority over test mode, which has priority over shifting.
    always_comb begin
        state_nxt    = state;
        shift_clr    = 1'b0;
        shift_en     = 1'b0;
        fwd_clk_nxt  = 1'b0;
        fwd_data_nxt = 1'b0;
        pub_word     = 1'b0;
        pub_test     = 1'b0;
        case (state)
            ST_SYNC: begin
                if (!s_frame) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_frame) begin
                    state_nxt = ST_CAPTURE;
                    shift_clr = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!s_frame) begin
                    state_nxt = ST_IDLE;
                end else if (test_mode) begin
                    state_nxt = ST_TEST;
                end else if (s_clk) begin
                    shift_en = 1'b1;
                    if (bit_counter == 5'd0) state_nxt = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (!s_frame) begin
                    state_nxt = ST_IDLE;
                    pub_word  = 1'b1;
                end else if (test_mode) begin
                    state_nxt = ST_TEST;
                end else begin
                    fwd_clk_nxt  = s_clk;
                    fwd_data_nxt = s_clk & s_data;
                end
            end
            ST_TEST: begin
                if (!s_frame) begin
                    state_nxt = ST_IDLE;
                    pub_test  = 1'b1;
                end
            end
            default: state_nxt = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_word  <= '0;
            led_valid <= 1'b0;
            fwd_clk   <= 1'b0;
            fwd_data  <= 1'b0;
            fwd_frame <= 1'b0;
        end else begin
            fwd_clk   <= fwd_clk_nxt;
            fwd_data  <= fwd_data_nxt;
            fwd_frame <= s_frame;
            led_valid <= pub_word | pub_test;
            if (pub_word) begin
                led_word <= shift_q;
            end else if (pub_test) begin
                led_word <= TEST_PATTERN;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_protocol_sequencer.sv
// Directed bench for the frame sequencer: capture, forwarding, short frames,
// test mode, mid-frame reset and back-to-back frames.
module tb_tt_um_hoene_protocol_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_clk = 1'b0;
    logic        s_data = 1'b0;
    logic        s_frame = 1'b0;
    logic [4:0]  bit_counter = 5'd0;
    logic        test_mode = 1'b0;
    logic [31:0] led_word;
    logic        led_valid;
    logic        fwd_clk;
    logic        fwd_data;
    logic        fwd_frame;

    int n_checks = 0;
    int n_errors = 0;

    // monitor state (cumulative; the main block takes snapshots)
    int          fwd_pulses = 0;
    int          valid_cnt = 0;
    int          late_err = 0;
    int          data_err = 0;
    int          align_err = 0;
    int          wide_err = 0;
    logic [31:0] fwd_shift = '0;
    logic [31:0] vw [0:31];
    logic        prev_s_clk = 1'b0;
    logic        prev_fwd_frame = 1'b0;
    logic        prev_valid = 1'b0;

    tt_um_hoene_protocol_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .s_clk       (s_clk),
        .s_data      (s_data),
        .s_frame     (s_frame),
        .bit_counter (bit_counter),
        .test_mode   (test_mode),
        .led_word    (led_word),
        .led_valid   (led_valid),
        .fwd_clk     (fwd_clk),
        .fwd_data    (fwd_data),
        .fwd_frame   (fwd_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fwd_clk) begin
            fwd_pulses = fwd_pulses + 1;
            fwd_shift  = {fwd_shift[30:0], fwd_data};
            if (!prev_s_clk) late_err = late_err + 1;
        end
        if (fwd_data && !fwd_clk) data_err = data_err + 1;
        if (led_valid) begin
            vw[valid_cnt % 32] = led_word;
            valid_cnt = valid_cnt + 1;
            if (!(prev_fwd_frame && !fwd_frame)) align_err = align_err + 1;
            if (prev_valid) wide_err = wide_err + 1;
        end
        prev_s_clk     = s_clk;
        prev_fwd_frame = fwd_frame;
        prev_valid     = led_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        s_frame = 1'b1;
    endtask

    task automatic send_bit(input logic b, input int idx);
        @(posedge clk); #1;
        s_clk       = 1'b1;
        s_data      = b;
        bit_counter = 5'(idx + 1);
        @(posedge clk); #1;
        s_clk  = 1'b0;
        s_data = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int base);
        for (int i = 0; i < 32; i++) send_bit(w[31-i], base + i);
    endtask

    task automatic end_frame(input int gap);
        @(posedge clk); #1;
        s_frame = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    int p0, v0;
    logic [31:0] w_tmp;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset led_word", led_word, 32'h0);
        chk("reset led_valid", 32'(led_valid), 32'h0);
        chk("reset fwd_clk", 32'(fwd_clk), 32'h0);
        chk("reset fwd_data", 32'(fwd_data), 32'h0);
        chk("reset fwd_frame", 32'(fwd_frame), 32'h0);

        // 64-bit frame: own word then one forwarded word
        p0 = fwd_pulses; v0 = valid_cnt;
        start_frame();
        @(posedge clk); #1;
        chk("fwd_frame follows s_frame", 32'(fwd_frame), 32'h1);
        send_word(32'hA5C3_0F81, 0);
        send_word(32'h1234_5678, 32);
        end_frame(4);
        chk("f64 led_word", led_word, 32'hA5C3_0F81);
        chk("f64 valid pulses", 32'(valid_cnt - v0), 32'd1);
        chk("f64 fwd pulses", 32'(fwd_pulses - p0), 32'd32);
        chk("f64 fwd word", fwd_shift, 32'h1234_5678);

        // 20-bit partial frame is discarded
        p0 = fwd_pulses; v0 = valid_cnt;
        start_frame();
        w_tmp = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) send_bit(w_tmp[31-i], i);
        end_frame(4);
        chk("f20 led_word kept", led_word, 32'hA5C3_0F81);
        chk("f20 no valid", 32'(valid_cnt - v0), 32'd0);
        chk("f20 no fwd", 32'(fwd_pulses - p0), 32'd0);

        // exactly 32 bits: published, nothing forwarded
        p0 = fwd_pulses; v0 = valid_cnt;
        start_frame();
        send_word(32'hFFFF_0000, 0);
        end_frame(4);
        chk("f32 led_word", led_word, 32'hFFFF_0000);
        chk("f32 valid pulses", 32'(valid_cnt - v0), 32'd1);
        chk("f32 no fwd", 32'(fwd_pulses - p0), 32'd0);

        // test mode raised with bit 42: only bits 32..41 forwarded
        p0 = fwd_pulses; v0 = valid_cnt;
        start_frame();
        send_word(32'h0BAD_CAFE, 0);
        w_tmp = 32'h1234_5678;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) test_mode = 1'b1;
            send_bit(w_tmp[31-i], 32 + i);
        end
        @(posedge clk); #1;
        s_frame   = 1'b0;
        test_mode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("test fwd pulses", 32'(fwd_pulses - p0), 32'd10);
        chk("test fwd bits", {22'd0, fwd_shift[9:0]}, 32'h0000_0048);
        chk("test led_word", led_word, 32'hFF00_FF00);
        chk("test valid pulses", 32'(valid_cnt - v0), 32'd1);

        // reset after 10 bits; rest of frame is ignored
        p0 = fwd_pulses; v0 = valid_cnt;
        start_frame();
        w_tmp = 32'h5555_AAAA;
        for (int i = 0; i < 10; i++) send_bit(w_tmp[31-i], i);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst led_word cleared", led_word, 32'h0);
        for (int i = 10; i < 64; i++) send_bit(i[0], i);
        end_frame(4);
        chk("rst no fwd", 32'(fwd_pulses - p0), 32'd0);
        chk("rst no valid", 32'(valid_cnt - v0), 32'd0);
        chk("rst led_word still 0", led_word, 32'h0);
        start_frame();
        send_word(32'hC001_D00D, 0);
        end_frame(4);
        chk("post-rst capture", led_word, 32'hC001_D00D);
        chk("post-rst valid", 32'(valid_cnt - v0), 32'd1);

        // back-to-back frames with a one-cycle gap
        v0 = valid_cnt;
        start_frame();
        send_word(32'h0BAD_F00D, 0);
        end_frame(1);
        s_frame = 1'b1;
        send_word(32'hCAFE_0001, 0);
        end_frame(4);
        chk("b2b valid pulses", 32'(valid_cnt - v0), 32'd2);
        chk("b2b word 1", vw[v0 % 32], 32'h0BAD_F00D);
        chk("b2b word 2", vw[(v0 + 1) % 32], 32'hCAFE_0001);

        chk("fwd latency errors", 32'(late_err), 32'd0);
        chk("fwd_data without fwd_clk", 32'(data_err), 32'd0);
        chk("led_valid vs fwd_frame fall", 32'(align_err), 32'd0);
        chk("led_valid wider than 1", 32'(wide_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
